// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: REQ -> WAIT -> FULL loop feeding decode,
// with branch/jump redirect that discards any in-flight memory response.
module instr_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [DATA_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_pc4_o,
  output logic [1:0]            dbg_state,
  output logic                  dbg_drop
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  state_t                  state, state_d;
  logic [DATA_WIDTH-1:0]   pc, pc_d, pc4, redir_pc;
  logic                    drop, drop_d;
  logic                    capture;

  assign pc4      = pc + DATA_WIDTH'(4);
  assign redir_pc = redirect_pc_i & ~DATA_WIDTH'(3);

  // Decode handshake: id_valid_o stays high with id_* frozen until a cycle where
  // id_ready_i is also high; that cycle completes the transfer. Redirect also ends it.
  assign id_valid_o  = (state == S_FULL);
  assign imem_req_o  = (state == S_REQ) && !rst;
  assign imem_addr_o = pc;
  assign dbg_state   = state;
  assign dbg_drop    = drop;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    drop_d  = drop;
    capture = 1'b0;
    case (state)
      S_REQ: begin
        if (imem_gnt_i) state_d = S_WAIT;
        if (redirect_i) begin
          pc_d = redir_pc;
          // A granted request to the stale PC is still in flight and must be dropped.
          if (imem_gnt_i) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          drop_d  = 1'b0;
          if (!drop && !redirect_i) begin
            capture = 1'b1;
            pc_d    = pc4;
            state_d = S_FULL;
          end
        end
        if (redirect_i) begin
          pc_d = redir_pc;
          if (!imem_rvalid_i) drop_d = 1'b1;
        end
      end
      S_FULL: begin
        if (id_ready_i || redirect_i) state_d = S_REQ;
        if (redirect_i) pc_d = redir_pc;
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      id_instr_o <= NOP_INSTR;
      id_pc_o    <= '0;
      id_pc4_o   <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      drop  <= drop_d;
      if (capture) begin
        id_instr_o <= imem_rdata_i;
        id_pc_o    <= pc;
        id_pc4_o   <= pc4;
      end
    end
  end

endmodule
